// File: rtl/k_divider_if.sv
`default_nettype none
// ============================================================================
//  Module      : k_divider_if
//  Description : Request/result bundle for the K-reload divider. The master
//                side issues start/abort and operands; the slave side (the
//                divider) returns the quotient/remainder and status.
//  Revision    : 1.0 - initial release
// ============================================================================
interface k_divider_if #(
    parameter int WIDTH = 16
);
    logic             start;
    logic             abort;
    logic [WIDTH-1:0] dividend;
    logic [WIDTH-1:0] divisor;
    logic [WIDTH-1:0] quotient;
    logic [WIDTH-1:0] remainder;
    logic             kcalc;
    logic             busy;
    logic             div_by_zero;

    modport master (
        output start, abort, dividend, divisor,
        input  quotient, remainder, kcalc, busy, div_by_zero
    );

    modport slave (
        input  start, abort, dividend, divisor,
        output quotient, remainder, kcalc, busy, div_by_zero
    );
endinterface
`default_nettype wire

// File: rtl/k_divider_seq.sv
`default_nettype none
// ============================================================================
//  Module      : k_divider_seq
//  Description : Multi-cycle restoring divider producing the count-reload
//                value K = dividend / divisor. One quotient bit per clock,
//                WIDTH steps, then a single DONE cycle whose kcalc pulse
//                tells the generator controller that K is ready.
//  Revision    : 1.0 - initial release
// ============================================================================
module k_divider_seq #(
    parameter int WIDTH = 16
) (
    input  wire logic     clk,
    input  wire logic     rst,
    k_divider_if.slave    bus
);

    localparam int         c_CW     = $clog2(WIDTH + 1);
    localparam logic [1:0] c_IDLE   = 2'd0;
    localparam logic [1:0] c_DIVIDE = 2'd1;
    localparam logic [1:0] c_DONE   = 2'd2;

    logic [1:0]       state_q, state_d;
    logic [WIDTH-1:0] shift_q, shift_d;   // dividend bits shifting out, quotient bits shifting in
    logic [WIDTH-1:0] prem_q,  prem_d;    // partial remainder
    logic [WIDTH-1:0] dvs_q,   dvs_d;     // latched divisor
    logic [c_CW-1:0]  cnt_q,   cnt_d;     // remaining restoring steps
    logic [WIDTH-1:0] quot_q,  quot_d;
    logic [WIDTH-1:0] rem_q,   rem_d;
    logic             dbz_q,   dbz_d;

    logic [WIDTH:0]   w_trial;
    logic [WIDTH:0]   w_diff;
    logic             w_qbit;
    logic [WIDTH-1:0] w_prem_nxt;
    logic [WIDTH-1:0] w_shift_nxt;

    // One restoring step: shift {prem, shift} left, trial-subtract the divisor.
    // Since prem < divisor, the WIDTH+1-bit difference is negative exactly
    // when its MSB is set, and a kept difference always fits in WIDTH bits.
    always_comb begin
        w_trial     = {prem_q, shift_q[WIDTH-1]};
        w_diff      = w_trial - {1'b0, dvs_q};
        w_qbit      = ~w_diff[WIDTH];
        w_prem_nxt  = w_qbit ? w_diff[WIDTH-1:0] : w_trial[WIDTH-1:0];
        w_shift_nxt = {shift_q[WIDTH-2:0], w_qbit};
    end

    // Sequencing FSM and datapath next-state; abort overrides everything.
    always_comb begin
        state_d = state_q;
        shift_d = shift_q;
        prem_d  = prem_q;
        dvs_d   = dvs_q;
        cnt_d   = cnt_q;
        quot_d  = quot_q;
        rem_d   = rem_q;
        dbz_d   = dbz_q;

        case (state_q)
            c_IDLE: begin
                if (bus.start) begin
                    if (bus.divisor != '0) begin
                        shift_d = bus.dividend;
                        dvs_d   = bus.divisor;
                        prem_d  = '0;
                        cnt_d   = c_CW'(WIDTH);
                        dbz_d   = 1'b0;
                        state_d = c_DIVIDE;
                    end else begin
                        quot_d  = '1;
                        rem_d   = bus.dividend;
                        dbz_d   = 1'b1;
                        state_d = c_DONE;
                    end
                end
            end
            c_DIVIDE: begin
                shift_d = w_shift_nxt;
                prem_d  = w_prem_nxt;
                cnt_d   = cnt_q - c_CW'(1);
                if (cnt_q == c_CW'(1)) begin
                    // Results land on the edge entering DONE so they are
                    // valid throughout the kcalc cycle.
                    quot_d  = w_shift_nxt;
                    rem_d   = w_prem_nxt;
                    state_d = c_DONE;
                end
            end
            c_DONE: begin
                state_d = c_IDLE;
            end
            default: begin
                state_d = c_IDLE;
            end
        endcase

        if (bus.abort) begin
            state_d = c_IDLE;
            shift_d = shift_q;
            prem_d  = prem_q;
            dvs_d   = dvs_q;
            cnt_d   = cnt_q;
            quot_d  = quot_q;
            rem_d   = rem_q;
            dbz_d   = dbz_q;
        end
    end

    // State and datapath registers with asynchronous reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= c_IDLE;
            shift_q <= '0;
            prem_q  <= '0;
            dvs_q   <= '0;
            cnt_q   <= '0;
            quot_q  <= '0;
            rem_q   <= '0;
            dbz_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            shift_q <= shift_d;
            prem_q  <= prem_d;
            dvs_q   <= dvs_d;
            cnt_q   <= cnt_d;
            quot_q  <= quot_d;
            rem_q   <= rem_d;
            dbz_q   <= dbz_d;
        end
    end

    assign bus.quotient    = quot_q;
    assign bus.remainder   = rem_q;
    assign bus.div_by_zero = dbz_q;
    assign bus.kcalc       = (state_q == c_DONE);
    assign bus.busy        = (state_q != c_IDLE);

endmodule
`default_nettype wire

// File: tb/tb_k_divider_seq.sv
`default_nettype none
// ============================================================================
//  Module      : tb_k_divider_seq
//  Description : Directed self-checking bench for k_divider_seq (WIDTH=16).
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_k_divider_seq;

    localparam int WIDTH = 16;

    logic clk;
    logic rst;
    int   checks;
    int   errors;
    int   n;

    k_divider_if #(.WIDTH(WIDTH)) bus ();

    k_divider_seq #(.WIDTH(WIDTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Wait (bounded) for kcalc; returns cycles elapsed since the current sample.
    task automatic wait_kcalc(output int cyc);
        cyc = 0;
        while (bus.kcalc !== 1'b1 && cyc < 64) begin
            tick();
            cyc++;
        end
    endtask

    // Launch one division, check latency, result and the single-cycle pulse.
    task automatic run_div(input string tag, input logic [15:0] dvd, input logic [15:0] dvs,
                           input int exp_lat, input logic [15:0] eq, input logic [15:0] er,
                           input logic exp_dbz);
        int lat;
        bus.dividend = dvd;
        bus.divisor  = dvs;
        bus.start    = 1'b1;
        tick();                       // start edge E
        bus.start    = 1'b0;
        bus.dividend = 16'hA5A5;      // operands may change after acceptance
        bus.divisor  = 16'h0003;
        wait_kcalc(lat);
        chk({tag, "_lat"}, lat, exp_lat);
        chk({tag, "_busy"}, {31'd0, bus.busy}, 1);
        chk({tag, "_q"}, {16'd0, bus.quotient}, {16'd0, eq});
        chk({tag, "_r"}, {16'd0, bus.remainder}, {16'd0, er});
        chk({tag, "_dbz"}, {31'd0, bus.div_by_zero}, {31'd0, exp_dbz});
        tick();
        chk({tag, "_kc_off"}, {31'd0, bus.kcalc}, 0);
        chk({tag, "_idle"}, {31'd0, bus.busy}, 0);
    endtask

    initial begin
        checks       = 0;
        errors       = 0;
        rst          = 1'b1;
        bus.start    = 1'b0;
        bus.abort    = 1'b0;
        bus.dividend = '0;
        bus.divisor  = '0;
        tick();
        tick();
        chk("rst_q", {16'd0, bus.quotient}, 0);
        chk("rst_r", {16'd0, bus.remainder}, 0);
        chk("rst_kcalc", {31'd0, bus.kcalc}, 0);
        chk("rst_busy", {31'd0, bus.busy}, 0);
        chk("rst_dbz", {31'd0, bus.div_by_zero}, 0);
        rst = 1'b0;
        tick();

        // Basic division and full-range / small-quotient cases (back-to-back).
        run_div("d1000_7", 16'd1000, 16'd7, 16, 16'd142, 16'd6, 1'b0);
        run_div("d65535_1", 16'd65535, 16'd1, 16, 16'd65535, 16'd0, 1'b0);
        run_div("d5_9", 16'd5, 16'd9, 16, 16'd0, 16'd5, 1'b0);

        // Divide by zero: kcalc in the cycle right after the start edge.
        run_div("dz1234", 16'd1234, 16'd0, 0, 16'hFFFF, 16'd1234, 1'b1);

        // Accepted start clears div_by_zero; abort at step 8 keeps prior result.
        bus.dividend = 16'd100;
        bus.divisor  = 16'd3;
        bus.start    = 1'b1;
        tick();
        bus.start    = 1'b0;
        chk("abt_dbz_clr", {31'd0, bus.div_by_zero}, 0);
        repeat (8) tick();
        bus.abort = 1'b1;
        tick();
        bus.abort = 1'b0;
        chk("abt_busy", {31'd0, bus.busy}, 0);
        chk("abt_kcalc", {31'd0, bus.kcalc}, 0);
        chk("abt_q", {16'd0, bus.quotient}, 32'hFFFF);
        chk("abt_r", {16'd0, bus.remainder}, 1234);
        n = 0;
        repeat (20) begin
            tick();
            if (bus.kcalc === 1'b1 || bus.busy === 1'b1) n++;
        end
        chk("abt_quiet", n, 0);
        run_div("d100_3", 16'd100, 16'd3, 16, 16'd33, 16'd1, 1'b0);

        // Start pulsed again mid-division with other operands is ignored.
        bus.dividend = 16'd1000;
        bus.divisor  = 16'd7;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (4) tick();
        bus.dividend = 16'd10;
        bus.divisor  = 16'd2;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        wait_kcalc(n);
        chk("ign_lat", n, 11);
        chk("ign_q", {16'd0, bus.quotient}, 142);
        chk("ign_r", {16'd0, bus.remainder}, 6);
        tick();

        // Start and abort together in IDLE: nothing happens.
        bus.dividend = 16'd50;
        bus.divisor  = 16'd5;
        bus.start    = 1'b1;
        bus.abort    = 1'b1;
        tick();
        bus.start = 1'b0;
        bus.abort = 1'b0;
        chk("sa_busy", {31'd0, bus.busy}, 0);
        tick();
        chk("sa_busy2", {31'd0, bus.busy}, 0);
        chk("sa_q", {16'd0, bus.quotient}, 142);

        // Asynchronous reset during DIVIDE, applied between clock edges.
        bus.dividend = 16'd1000;
        bus.divisor  = 16'd7;
        bus.start    = 1'b1;
        tick();
        bus.start = 1'b0;
        repeat (3) tick();
        rst = 1'b1;
        #1;
        chk("arst_q", {16'd0, bus.quotient}, 0);
        chk("arst_r", {16'd0, bus.remainder}, 0);
        chk("arst_busy", {31'd0, bus.busy}, 0);
        chk("arst_kcalc", {31'd0, bus.kcalc}, 0);
        #1;
        rst = 1'b0;
        tick();
        run_div("d500_25", 16'd500, 16'd25, 16, 16'd20, 16'd0, 1'b0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
